// File: rtl/rf_wb_scheduler_if.sv
// rtl/rf_wb_scheduler_if.sv - decode/writeback/reg_file signal bundle for rf_wb_scheduler
//
// Purpose: groups the claim, read-hazard, writeback-request and reg_file write
// signals of the register-file write scheduler.
// master: decode stage, writeback requesters and reg_file side (testbench / CPU).
// slave : rf_wb_scheduler.
//   claim_valid/claim_enc/claim_ready   destination claim from decode
//   rd_en/rd_enc_0/rd_enc_1/rd_stall    decode source read hazard check
//   req_valid/req_enc/req_data/req_ready two writeback requesters (index 0 = ALU)
//   we/r_write_enc/wdata                registered reg_file write port
//   busy/unclaimed_err/wr_count          scoreboard and status
interface rf_wb_scheduler_if #(
    parameter int NUM_REGS = 4,
    parameter int ENC_W    = 2,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
);
    logic                  claim_valid;
    logic [ENC_W-1:0]      claim_enc;
    logic                  claim_ready;
    logic [1:0]            rd_en;
    logic [ENC_W-1:0]      rd_enc_0;
    logic [ENC_W-1:0]      rd_enc_1;
    logic                  rd_stall;
    logic [1:0]            req_valid;
    logic [2*ENC_W-1:0]    req_enc;
    logic [2*DATA_W-1:0]   req_data;
    logic [1:0]            req_ready;
    logic                  we;
    logic [ENC_W-1:0]      r_write_enc;
    logic [DATA_W-1:0]     wdata;
    logic [NUM_REGS-1:0]   busy;
    logic                  unclaimed_err;
    logic [CNT_W-1:0]      wr_count;

    modport master (
        output claim_valid, claim_enc, rd_en, rd_enc_0, rd_enc_1,
               req_valid, req_enc, req_data,
        input  claim_ready, rd_stall, req_ready, we, r_write_enc, wdata,
               busy, unclaimed_err, wr_count
    );

    modport slave (
        input  claim_valid, claim_enc, rd_en, rd_enc_0, rd_enc_1,
               req_valid, req_enc, req_data,
        output claim_ready, rd_stall, req_ready, we, r_write_enc, wdata,
               busy, unclaimed_err, wr_count
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - round-robin writeback scheduler and scoreboard for the reg_file write port
//
// Purpose: arbitrates two writeback requesters onto the single reg_file write
// port, tracks in-flight destinations in a busy scoreboard and flags read
// hazards toward decode.
// Ports:
//   clk     system clock
//   resetn  synchronous active-low reset
//   bus     rf_wb_scheduler_if.slave (claim, read hazard, requests, reg_file write, status)
module rf_wb_scheduler #(
    parameter int NUM_REGS = 4,
    parameter int ENC_W    = 2,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                resetn,
    rf_wb_scheduler_if.slave    bus
);

    logic                r_we;
    logic [ENC_W-1:0]    r_wr_enc;
    logic [DATA_W-1:0]   r_wr_data;
    logic [NUM_REGS-1:0] r_busy;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rr_last;

    logic [1:0]          w_grant;
    logic                w_gnt_any;
    logic                w_gnt_idx;
    logic [ENC_W-1:0]    w_gnt_enc;
    logic [DATA_W-1:0]   w_gnt_data;
    logic                w_claim_fire;
    logic                w_unclaimed;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Tie goes to the requester that was not granted last; rr_last resets to 1
    // so requester 0 wins the first tie.
    always_comb begin
        w_grant = 2'b00;
        case (bus.req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_rr_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_gnt_any  = |w_grant;
    assign w_gnt_idx  = w_grant[1];
    assign w_gnt_enc  = w_gnt_idx ? bus.req_enc[2*ENC_W-1:ENC_W]    : bus.req_enc[ENC_W-1:0];
    assign w_gnt_data = w_gnt_idx ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];

    assign w_claim_fire = bus.claim_valid & bus.claim_ready;

    // A write racing the claim of its own destination is legitimate.
    assign w_unclaimed = w_gnt_any & ~r_busy[w_gnt_enc]
                       & ~(w_claim_fire && (bus.claim_enc == w_gnt_enc));

    // Commit clears the destination of the write presented this cycle; a claim
    // can only target a non-busy register, so it never fights that clear.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_wr_enc] = 1'b0;
        end
        if (w_claim_fire) begin
            w_busy_nxt[bus.claim_enc] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_we      <= 1'b0;
            r_wr_enc  <= '0;
            r_wr_data <= '0;
            r_busy    <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_rr_last <= 1'b1;
        end else begin
            r_we   <= w_gnt_any;
            r_busy <= w_busy_nxt;
            if (w_gnt_any) begin
                r_wr_enc  <= w_gnt_enc;
                r_wr_data <= w_gnt_data;
                r_rr_last <= w_gnt_idx;
            end
            if (w_unclaimed) begin
                r_err <= 1'b1;
            end
            if (r_we) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.claim_ready   = ~r_busy[bus.claim_enc];
    assign bus.rd_stall      = (bus.rd_en[0] & r_busy[bus.rd_enc_0])
                             | (bus.rd_en[1] & r_busy[bus.rd_enc_1]);
    assign bus.req_ready     = w_grant;
    assign bus.we            = r_we;
    assign bus.r_write_enc   = r_wr_enc;
    assign bus.wdata         = r_wr_data;
    assign bus.busy          = r_busy;
    assign bus.unclaimed_err = r_err;
    assign bus.wr_count      = r_cnt;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - directed scoreboard bench for rf_wb_scheduler with a behavioural reg_file
module tb_rf_wb_scheduler;
    localparam int NUM_REGS = 4;
    localparam int ENC_W    = 2;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 16;

    logic clk;
    logic resetn;

    int n_total = 0;
    int n_pass  = 0;

    logic [ENC_W+DATA_W-1:0] sb_q[$];
    logic [DATA_W-1:0]       rf [NUM_REGS];

    rf_wb_scheduler_if #(.NUM_REGS(NUM_REGS), .ENC_W(ENC_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    rf_wb_scheduler #(.NUM_REGS(NUM_REGS), .ENC_W(ENC_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // reg_file: reset value 3, captures the registered write at negedge
    always @(negedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= 32'd3;
        end else if (bus.we) begin
            rf[bus.r_write_enc] <= bus.wdata;
            check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                logic [ENC_W+DATA_W-1:0] e;
                e = sb_q.pop_front();
                check("sb_enc",  64'(bus.r_write_enc), 64'(e[ENC_W+DATA_W-1:DATA_W]));
                check("sb_data", 64'(bus.wdata),       64'(e[DATA_W-1:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.claim_valid = 1'b0;
        bus.claim_enc   = '0;
        bus.rd_en       = 2'b00;
        bus.rd_enc_0    = '0;
        bus.rd_enc_1    = '0;
        bus.req_valid   = 2'b00;
        bus.req_enc     = '0;
        bus.req_data    = '0;
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        resetn = 1'b1;
    endtask

    initial begin
        idle();
        resetn = 1'b0;

        // T1 reset
        do_reset(2);
        check("t1_we",        64'(bus.we), 64'd0);
        check("t1_busy",      64'(bus.busy), 64'd0);
        check("t1_wr_count",  64'(bus.wr_count), 64'd0);
        check("t1_err",       64'(bus.unclaimed_err), 64'd0);
        check("t1_claim_rdy", 64'(bus.claim_ready), 64'd1);
        check("t1_rf0",       64'(rf[0]), 64'd3);

        // T2 single write to R2
        bus.claim_valid = 1'b1; bus.claim_enc = 2'd2;
        settle();
        check("t2_claim_rdy", 64'(bus.claim_ready), 64'd1);
        step();
        bus.claim_valid = 1'b0;
        settle();
        check("t2_busy_set", 64'(bus.busy), 64'b0100);
        bus.req_valid = 2'b01; bus.req_enc = {2'd0, 2'd2}; bus.req_data = {32'd0, 32'hA5};
        sb_q.push_back({2'd2, 32'hA5});
        settle();
        check("t2_ready", 64'(bus.req_ready), 64'b01);
        step();
        bus.req_valid = 2'b00;
        settle();
        check("t2_we",   64'(bus.we), 64'd1);
        check("t2_enc",  64'(bus.r_write_enc), 64'd2);
        check("t2_data", 64'(bus.wdata), 64'hA5);
        check("t2_busy_held", 64'(bus.busy), 64'b0100);
        step();
        check("t2_rf2",      64'(rf[2]), 64'hA5);
        check("t2_busy_clr", 64'(bus.busy), 64'd0);
        check("t2_wr_count", 64'(bus.wr_count), 64'd1);
        check("t2_we_drop",  64'(bus.we), 64'd0);

        // T3 tie: fresh reset so the round-robin pointer starts at its reset value
        do_reset(1);
        bus.claim_valid = 1'b1; bus.claim_enc = 2'd0;
        step();
        bus.claim_enc = 2'd1;
        step();
        bus.claim_valid = 1'b0;
        bus.req_valid = 2'b11; bus.req_enc = {2'd1, 2'd0}; bus.req_data = {32'd20, 32'd10};
        sb_q.push_back({2'd0, 32'd10});
        sb_q.push_back({2'd1, 32'd20});
        settle();
        check("t3_busy",   64'(bus.busy), 64'b0011);
        check("t3_grant0", 64'(bus.req_ready), 64'b01);
        step();
        bus.req_valid = 2'b10;
        settle();
        check("t3_grant1", 64'(bus.req_ready), 64'b10);
        step();
        bus.req_valid = 2'b00;
        step();
        check("t3_rf0",      64'(rf[0]), 64'd10);
        check("t3_rf1",      64'(rf[1]), 64'd20);
        check("t3_wr_count", 64'(bus.wr_count), 64'd2);
        check("t3_busy_clr", 64'(bus.busy), 64'd0);

        // T4 read hazard on R3
        bus.claim_valid = 1'b1; bus.claim_enc = 2'd3;
        step();
        bus.claim_valid = 1'b0;
        bus.rd_en = 2'b01; bus.rd_enc_0 = 2'd3; bus.rd_enc_1 = 2'd0;
        settle();
        check("t4_stall_claimed", 64'(bus.rd_stall), 64'd1);
        bus.req_valid = 2'b01; bus.req_enc = {2'd0, 2'd3}; bus.req_data = {32'd0, 32'hC3};
        sb_q.push_back({2'd3, 32'hC3});
        step();
        bus.req_valid = 2'b00;
        settle();
        check("t4_stall_we", 64'(bus.rd_stall), 64'd1);
        step();
        settle();
        check("t4_stall_rel", 64'(bus.rd_stall), 64'd0);
        check("t4_rf3",       64'(rf[3]), 64'hC3);
        bus.rd_en = 2'b00;

        // T5 WAW on R1, then an unclaimed write to R0
        bus.claim_valid = 1'b1; bus.claim_enc = 2'd1;
        settle();
        check("t5_claim1_rdy", 64'(bus.claim_ready), 64'd1);
        step();
        settle();
        check("t5_claim2_blk", 64'(bus.claim_ready), 64'd0);
        bus.req_valid = 2'b10; bus.req_enc = {2'd1, 2'd0}; bus.req_data = {32'h55, 32'd0};
        sb_q.push_back({2'd1, 32'h55});
        settle();
        check("t5_ready1", 64'(bus.req_ready), 64'b10);
        step();
        bus.req_valid = 2'b00;
        settle();
        check("t5_claim2_wait", 64'(bus.claim_ready), 64'd0);
        step();
        settle();
        check("t5_claim2_rdy", 64'(bus.claim_ready), 64'd1);
        step();
        bus.claim_valid = 1'b0;
        settle();
        check("t5_busy_r1",   64'(bus.busy), 64'b0010);
        check("t5_err_clean", 64'(bus.unclaimed_err), 64'd0);
        bus.req_valid = 2'b01; bus.req_enc = {2'd0, 2'd0}; bus.req_data = {32'd0, 32'h77};
        sb_q.push_back({2'd0, 32'h77});
        step();
        bus.req_valid = 2'b00;
        settle();
        check("t5_err_set", 64'(bus.unclaimed_err), 64'd1);
        step();
        check("t5_wr_count",  64'(bus.wr_count), 64'd5);
        check("t5_rf0",       64'(rf[0]), 64'h77);
        check("t5_err_stick", 64'(bus.unclaimed_err), 64'd1);

        // T6 reset while both requests are pending
        bus.claim_valid = 1'b1; bus.claim_enc = 2'd0;
        step();
        bus.claim_valid = 1'b0;
        bus.req_valid = 2'b11; bus.req_enc = {2'd1, 2'd0}; bus.req_data = {32'h99, 32'h88};
        resetn = 1'b0;
        step();
        settle();
        check("t6_busy", 64'(bus.busy), 64'd0);
        check("t6_we",   64'(bus.we), 64'd0);
        check("t6_err",  64'(bus.unclaimed_err), 64'd0);
        check("t6_cnt",  64'(bus.wr_count), 64'd0);
        step();
        resetn = 1'b1;
        settle();
        check("t6_rf0",  64'(rf[0]), 64'd3);
        check("t6_rf1",  64'(rf[1]), 64'd3);
        check("t6_tie_after_reset", 64'(bus.req_ready), 64'b01);
        bus.req_valid = 2'b00;
        step();
        step();
        check("t6_we_idle",  64'(bus.we), 64'd0);
        check("sb_drained",  64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
